// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared DMI op/response codes, widths and request/response types
package dm_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_OP_W   = 2;
    localparam int DMI_DATA_W = 32;
    localparam int DMI_REQ_W  = DMI_ADDR_W + DMI_OP_W + DMI_DATA_W;
    localparam int DMI_RESP_W = DMI_DATA_W + 2;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_OP_W-1:0]   op;
        logic [DMI_DATA_W-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DMI_DATA_W-1:0] data;
        logic [1:0]            resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dmi_state_e;

endpackage

// File: rtl/dm_dmi_host.sv
// rtl/dm_dmi_host.sv - host-side DMI master with sticky error and response timeout
module dm_dmi_host
    import dm_pkg::*;
#(
    parameter int TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req_valid_i,
    output logic        host_req_ready_o,
    input  logic [6:0]  host_addr_i,
    input  logic [1:0]  host_op_i,
    input  logic [31:0] host_data_i,
    output logic        host_resp_valid_o,
    input  logic        host_resp_ready_i,
    output logic [31:0] host_resp_data_o,
    output logic [1:0]  host_resp_status_o,
    input  logic        dmi_clear_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [40:0] dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i,
    output logic        busy_o
);

    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    dmi_state_e      state_q;
    dmi_req_t        req_q;
    dmi_resp_t       resp_w;
    logic [31:0]     rdata_q;
    logic [1:0]      sticky_q;
    logic [1:0]      status_q;
    logic [CntW-1:0] cnt_q;
    logic            sticky_set;

    assign resp_w = dmi_resp_i;

    // Events that raise the sticky error: reserved op, error response, or timeout.
    always_comb begin
        sticky_set = 1'b0;
        case (state_q)
            ST_IDLE: sticky_set = host_req_valid_i && (host_op_i == DMI_OP_RSVD);
            ST_WAIT: begin
                if (dmi_resp_valid_i) begin
                    sticky_set = (resp_w.resp != DMI_RESP_SUCCESS);
                end else begin
                    sticky_set = (cnt_q == CntLast);
                end
            end
            default: sticky_set = 1'b0;
        endcase
    end

    // Sticky error: a new failure beats a simultaneous clear; independent of the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 2'd0;
        end else if (sticky_set) begin
            sticky_q <= DMI_RESP_FAILED;
        end else if (dmi_clear_i) begin
            sticky_q <= 2'd0;
        end
    end

    // Transaction FSM; status is captured on RESP entry so later clears cannot alter it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            rdata_q  <= 32'd0;
            status_q <= 2'd0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (host_req_valid_i) begin
                        case (host_op_i)
                            DMI_OP_NOP: begin
                                status_q <= sticky_q;
                                state_q  <= ST_RESP;
                            end
                            DMI_OP_READ, DMI_OP_WRITE: begin
                                if (sticky_q != 2'd0) begin
                                    status_q <= sticky_q;
                                    state_q  <= ST_RESP;
                                end else begin
                                    req_q.addr <= host_addr_i;
                                    req_q.op   <= host_op_i;
                                    req_q.data <= host_data_i;
                                    state_q    <= ST_REQ;
                                end
                            end
                            default: begin
                                status_q <= DMI_RESP_FAILED;
                                state_q  <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_REQ: begin
                    if (dmi_req_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmi_resp_valid_i) begin
                        if (resp_w.resp == DMI_RESP_SUCCESS) begin
                            if (req_q.op == DMI_OP_READ) begin
                                rdata_q <= resp_w.data;
                            end
                            status_q <= DMI_RESP_SUCCESS;
                        end else begin
                            status_q <= DMI_RESP_FAILED;
                        end
                        state_q <= ST_RESP;
                    end else if (cnt_q == CntLast) begin
                        status_q <= DMI_RESP_FAILED;
                        state_q  <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (host_resp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host_req_ready_o   = (state_q == ST_IDLE);
    assign busy_o             = (state_q != ST_IDLE);
    assign dmi_req_valid_o    = (state_q == ST_REQ);
    assign dmi_resp_ready_o   = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign host_resp_valid_o  = (state_q == ST_RESP);
    assign dmi_req_o          = req_q;
    assign host_resp_data_o   = rdata_q;
    assign host_resp_status_o = status_q;

endmodule

// File: tb/tb_dm_dmi_host.sv
// tb/tb_dm_dmi_host.sv - self-checking bench for dm_dmi_host against a transaction-level model
module tb_dm_dmi_host;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        host_req_valid_i;
    logic        host_req_ready_o;
    logic [6:0]  host_addr_i;
    logic [1:0]  host_op_i;
    logic [31:0] host_data_i;
    logic        host_resp_valid_o;
    logic        host_resp_ready_i;
    logic [31:0] host_resp_data_o;
    logic [1:0]  host_resp_status_o;
    logic        dmi_clear_i;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [40:0] dmi_req_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [33:0] dmi_resp_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    logic [1:0]  m_sticky;
    logic [31:0] m_rdata;

    dm_dmi_host #(.TimeoutCycles(TO)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .host_req_valid_i   (host_req_valid_i),
        .host_req_ready_o   (host_req_ready_o),
        .host_addr_i        (host_addr_i),
        .host_op_i          (host_op_i),
        .host_data_i        (host_data_i),
        .host_resp_valid_o  (host_resp_valid_o),
        .host_resp_ready_i  (host_resp_ready_i),
        .host_resp_data_o   (host_resp_data_o),
        .host_resp_status_o (host_resp_status_o),
        .dmi_clear_i        (dmi_clear_i),
        .dmi_req_valid_o    (dmi_req_valid_o),
        .dmi_req_ready_i    (dmi_req_ready_i),
        .dmi_req_o          (dmi_req_o),
        .dmi_resp_valid_i   (dmi_resp_valid_i),
        .dmi_resp_ready_o   (dmi_resp_ready_o),
        .dmi_resp_i         (dmi_resp_i),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic scramble_host_inputs();
        host_op_i   = 2'($urandom);
        host_addr_i = 7'($urandom);
        host_data_i = $urandom;
    endtask

    // One host transaction; the model decides whether DMI traffic should occur and what status results.
    task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                       input int req_stall, input int resp_delay, input logic [1:0] code,
                       input logic [31:0] rdata, input bit no_resp, input bit clr_in_resp,
                       input bit clr_at_resp);
        bit         traffic;
        logic [1:0] exp_status;
        logic [40:0] exp_word;
        int         n;
        traffic  = ((op == 2'd1) || (op == 2'd2)) && (m_sticky == 2'd0);
        exp_word = {addr, op, wdata};
        check("idle_req_ready", 64'(host_req_ready_o), 64'd1);
        host_req_valid_i = 1'b1;
        host_addr_i      = addr;
        host_op_i        = op;
        host_data_i      = wdata;
        step();
        host_req_valid_i = 1'b0;
        scramble_host_inputs();
        if (traffic) begin
            check("req_valid", 64'(dmi_req_valid_o), 64'd1);
            check("req_word", 64'(dmi_req_o), 64'(exp_word));
            for (int i = 0; i < req_stall; i++) begin
                step();
                check("req_stall_valid", 64'(dmi_req_valid_o), 64'd1);
                check("req_stall_word", 64'(dmi_req_o), 64'(exp_word));
            end
            dmi_req_ready_i = 1'b1;
            step();
            dmi_req_ready_i = 1'b0;
            check("req_dropped", 64'(dmi_req_valid_o), 64'd0);
            check("wait_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
            if (no_resp) begin
                n = 0;
                while (!host_resp_valid_o && n < 200) begin
                    step();
                    n++;
                end
                check("timeout_latency", 64'(n), 64'(TO));
                m_sticky   = 2'd2;
                exp_status = 2'd2;
            end else begin
                for (int i = 0; i < resp_delay; i++) begin
                    step();
                    check("wait_no_host_resp", 64'(host_resp_valid_o), 64'd0);
                end
                dmi_resp_valid_i = 1'b1;
                dmi_resp_i       = {rdata, code};
                dmi_clear_i      = clr_at_resp;
                step();
                dmi_resp_valid_i = 1'b0;
                dmi_clear_i      = 1'b0;
                dmi_resp_i       = {$urandom, 2'($urandom)};
                check("dmi_resp_latency", 64'(host_resp_valid_o), 64'd1);
                if (code == 2'd0) begin
                    if (op == 2'd1) m_rdata = rdata;
                    exp_status = 2'd0;
                    if (clr_at_resp) m_sticky = 2'd0;
                end else begin
                    m_sticky   = 2'd2;
                    exp_status = 2'd2;
                end
            end
        end else begin
            check("no_dmi_traffic", 64'(dmi_req_valid_o), 64'd0);
            check("short_latency", 64'(host_resp_valid_o), 64'd1);
            exp_status = (op == 2'd3) ? 2'd2 : m_sticky;
            if (op == 2'd3) m_sticky = 2'd2;
        end
        check("resp_status", 64'(host_resp_status_o), 64'(exp_status));
        check("resp_data", 64'(host_resp_data_o), 64'(m_rdata));
        if (clr_in_resp) begin
            dmi_clear_i = 1'b1;
            step();
            dmi_clear_i = 1'b0;
            m_sticky    = 2'd0;
            check("resp_held", 64'(host_resp_valid_o), 64'd1);
            check("status_frozen", 64'(host_resp_status_o), 64'(exp_status));
        end
        host_resp_ready_i = 1'b1;
        step();
        host_resp_ready_i = 1'b0;
        check("back_to_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic clear_pulse();
        dmi_clear_i = 1'b1;
        step();
        dmi_clear_i = 1'b0;
        m_sticky    = 2'd0;
    endtask

    initial begin
        rst_i             = 1'b1;
        host_req_valid_i  = 1'b0;
        host_addr_i       = '0;
        host_op_i         = '0;
        host_data_i       = '0;
        host_resp_ready_i = 1'b0;
        dmi_clear_i       = 1'b0;
        dmi_req_ready_i   = 1'b0;
        dmi_resp_valid_i  = 1'b0;
        dmi_resp_i        = '0;
        m_sticky          = 2'd0;
        m_rdata           = 32'd0;

        step();
        step();
        rst_i = 1'b0;
        check("rst_req_ready", 64'(host_req_ready_o), 64'd1);
        check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        check("rst_resp_valid", 64'(host_resp_valid_o), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check("rst_req_word", 64'(dmi_req_o), 64'd0);
        check("rst_data", 64'(host_resp_data_o), 64'd0);
        check("rst_status", 64'(host_resp_status_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);

        // Directed write, then stalled read.
        txn(2'd2, 7'h10, 32'h1, 0, 1, 2'd0, 32'h0, 0, 0, 0);
        txn(2'd1, 7'h04, $urandom, 3, 2, 2'd0, 32'hDEADBEEF, 0, 0, 0);

        // Failed read makes the error sticky; writes are blocked until cleared.
        txn(2'd1, 7'h11, 32'h0, 0, 0, 2'd2, $urandom, 0, 0, 0);
        txn(2'd2, 7'h12, 32'hCAFE, 0, 0, 2'd0, 32'h0, 0, 0, 0);
        clear_pulse();
        txn(2'd2, 7'h12, 32'hCAFE, 1, 0, 2'd0, $urandom, 0, 0, 0);

        // NOP reports the last read; reserved op fails.
        txn(2'd1, 7'h20, 32'h0, 0, 0, 2'd0, 32'h12345678, 0, 0, 0);
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);
        txn(2'd3, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);
        clear_pulse();

        // Timeout, then a late response in IDLE must be ignored.
        txn(2'd1, 7'h30, 32'h0, 0, 0, 2'd0, 32'h0, 1, 0, 0);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {32'hBAADF00D, 2'd0};
        step();
        dmi_resp_valid_i = 1'b0;
        check("late_resp_idle", 64'(busy_o), 64'd0);
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);
        clear_pulse();
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);

        // Clear during RESP leaves the presented status alone.
        txn(2'd3, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 1, 0);
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);

        // Error response with a simultaneous clear: the error wins.
        txn(2'd2, 7'h05, $urandom, 0, 1, 2'd2, $urandom, 0, 0, 1);
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);
        clear_pulse();

        // Reset while waiting for a response, then a stray error response.
        host_req_valid_i = 1'b1;
        host_op_i        = 2'd1;
        host_addr_i      = 7'h44;
        step();
        host_req_valid_i = 1'b0;
        dmi_req_ready_i  = 1'b1;
        step();
        dmi_req_ready_i  = 1'b0;
        check("pre_rst_wait", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        m_sticky = 2'd0;
        m_rdata  = 32'd0;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_req_ready", 64'(host_req_ready_o), 64'd1);
        check("midrst_req_word", 64'(dmi_req_o), 64'd0);
        check("midrst_data", 64'(host_resp_data_o), 64'd0);
        check("midrst_status", 64'(host_resp_status_o), 64'd0);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {32'h55AA55AA, 2'd2};
        step();
        dmi_resp_valid_i = 1'b0;
        check("stray_idle", 64'(busy_o), 64'd0);
        txn(2'd0, 7'h00, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);

        // Randomized transactions against the model.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] r_op;
            logic [1:0] r_code;
            int         sel;
            sel    = $urandom_range(0, 9);
            r_op   = (sel < 4) ? 2'd1 : (sel < 8) ? 2'd2 : (sel < 9) ? 2'd0 : 2'd3;
            r_code = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
            if ($urandom_range(0, 3) == 0) clear_pulse();
            txn(r_op, 7'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                r_code, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_dmi_host.md
DM_DMI_HOST -- requirements
Module: dm_dmi_host

Interface
REQ-001 Parameter TimeoutCycles, default 1024, is the maximum number of cycles spent waiting for a DMI response (range 2..65535).
REQ-002 Port clk_i, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 Port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 Port host_req_valid_i, input, 1, host command valid.
REQ-005 Port host_req_ready_o, output, 1, host command accepted when high together with valid.
REQ-006 Port host_addr_i, input, 7, DMI register address.
REQ-007 Port host_op_i, input, 2, operation: 0 NOP, 1 read, 2 write, 3 reserved.
REQ-008 Port host_data_i, input, 32, write data.
REQ-009 Port host_resp_valid_o, input/output as follows: output, 1, host response valid.
REQ-010 Port host_resp_ready_i, input, 1, host consumes the response.
REQ-011 Port host_resp_data_o, output, 32, read data, which is the last successful read value.
REQ-012 Port host_resp_status_o, output, 2, status: 0 success, 2 failed.
REQ-013 Port dmi_clear_i, input, 1, clears the sticky error.
REQ-014 Port dmi_req_valid_o, output, 1, DMI request valid.
REQ-015 Port dmi_req_ready_i, input, 1, DMI request ready.
REQ-016 Port dmi_req_o, output, 41, DMI request with fields {addr[40:34], op[33:32], data[31:0]}.
REQ-017 Port dmi_resp_valid_i, input, 1, DMI response valid.
REQ-018 Port dmi_resp_ready_o, output, 1, DMI response ready.
REQ-019 Port dmi_resp_i, input, 34, DMI response with fields {data[33:2], resp[1:0]}.
REQ-020 Port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.
REQ-022 host_req_ready_o SHALL be 1 in IDLE only; a request is accepted on valid&&ready.
REQ-023 Accept of a read or write with sticky error = 0 -> latch addr/op/data into dmi_req_o and go to REQ.
REQ-024 Accept of a read or write with sticky error != 0 -> go to RESP without any DMI traffic, status = sticky value.
REQ-025 Accept of a NOP -> go to RESP, status = sticky value, no DMI traffic.
REQ-026 Accept of op 3 -> set sticky = 2 and go to RESP with status 2, no DMI traffic.
REQ-027 In REQ, dmi_req_valid_o SHALL be 1 and dmi_req_o SHALL be stable until dmi_req_ready_i; on the handshake the FSM goes to WAIT and the timeout counter clears.
REQ-028 In WAIT, dmi_resp_ready_o SHALL be 1; on dmi_resp_valid_i the FSM goes to RESP.
REQ-029 In WAIT with resp = 0 and a read op -> the read-data register SHALL take dmi_resp_i[33:2].
REQ-030 In WAIT with resp != 0 -> sticky = 2 and status 2; the read-data register is unchanged.
REQ-031 Write responses SHALL never update the read-data register.
REQ-032 Timeout: in WAIT the counter increments each cycle without a response; at TimeoutCycles-1 -> sticky = 2, go to RESP with status 2.
REQ-033 In IDLE, dmi_resp_ready_o SHALL be 1, so a late or stray response is discarded without effect.
REQ-034 In RESP, host_resp_valid_o SHALL be 1 with data and status stable until host_resp_ready_i, then the FSM goes to IDLE.
REQ-035 Latency: an accepted NOP, op 3 or sticky-blocked request SHALL give host_resp_valid_o exactly 1 cycle after accept.
REQ-036 Latency: a DMI op SHALL give host_resp_valid_o 1 cycle after the response handshake.
REQ-037 dmi_clear_i SHALL zero the sticky error in any state without affecting the FSM; if a set and a clear occur in the same cycle, the set wins.
REQ-038 The status presented in RESP SHALL be frozen at RESP entry; a clear during RESP does not change it.
REQ-039 dmi_req_valid_o and dmi_resp_ready_o SHALL never both be 1 outside IDLE/WAIT overlap rules; dmi_req_valid_o is 0 in every state except REQ.

Reset
REQ-040 When rst_i is high at a clock edge, the FSM SHALL be in IDLE and the sticky error, read-data register, timeout counter and latched request SHALL all be 0.
REQ-041 Reset values of the outputs SHALL be: host_req_ready_o = 1, dmi_resp_ready_o = 1, and every other output = 0.
REQ-042 A reset mid-transaction SHALL abandon the transaction; any DMI response that arrives afterwards is discarded under REQ-033.

Structure
REQ-043 The DMI op, response-code and width constants, dmi_req_t (41 bits) and dmi_resp_t (34 bits) SHALL live in the shared dm package.
REQ-044 The block SHALL be a single module with no sub-modules; the timeout counter is inline with a width of $clog2(TimeoutCycles).

Verification
REQ-045 Write addr 0x10 data 0x00000001 -> dmi_req_o = {0x10, 2, 0x1} held until ready; resp 0 -> status 0, sticky 0.
REQ-046 Read addr 0x04 with response data 0xDEADBEEF, resp 0, ready delayed 3 cycles -> host data 0xDEADBEEF, status 0, request stable while stalled.
REQ-047 Read with resp = 2 -> status 2; a following write SHALL produce status 2 with no dmi_req_valid_o; after dmi_clear_i, a write SHALL reach the DMI.
REQ-048 With TimeoutCycles = 8 and no response -> status 2 exactly 8 cycles after the request handshake; a late response in IDLE is ignored and the read data is unchanged.
REQ-049 NOP after a successful read of 0x12345678 -> data 0x12345678, status 0, 1-cycle latency; op 3 -> status 2.
REQ-050 rst_i asserted in WAIT -> next cycle IDLE with all state at zero; a later stray response is dropped.
